// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - four-digit multiplexed hex display scanner with frame-synchronous value update
module display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [4:0]  digit_code,
    output logic [3:0]  anode_n,
    output logic        busy,
    output logic        frame_tick
);

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [4:0]  CODE_BLANK = 5'd16;

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [15:0] disp_q;
    logic [15:0] pend_q;

    logic        slot_end;
    logic        frame_end;
    logic        xfer;
    logic [3:0]  nibble;
    logic        upper_zero;
    logic [4:0]  code_next;

    always_comb begin
        slot_end  = en && (cnt == CNT_LAST);
        frame_end = slot_end && (idx == 2'd3);
        // Swapping only at a frame edge (or while dark) keeps a frame from mixing old and new digits
        xfer      = busy && (frame_end || !en);
    end

    // upper_zero: this digit and every digit to its left are zero; digit 0 is never blanked
    always_comb begin
        nibble     = disp_q[3:0];
        upper_zero = 1'b0;
        case (idx)
            2'd0: begin
                nibble     = disp_q[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nibble     = disp_q[7:4];
                upper_zero = (disp_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble     = disp_q[11:8];
                upper_zero = (disp_q[15:8] == 8'h00);
            end
            default: begin
                nibble     = disp_q[15:12];
                upper_zero = (disp_q[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        if (!en) begin
            code_next = CODE_BLANK;
        end else if (blank_lz && upper_zero) begin
            code_next = CODE_BLANK;
        end else begin
            code_next = {1'b0, nibble};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 16'd0;
            idx        <= 2'd0;
            disp_q     <= 16'h0000;
            pend_q     <= 16'h0000;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            anode_n    <= 4'b1111;
            digit_code <= CODE_BLANK;
        end else begin
            if (!en) begin
                cnt <= 16'd0;
                idx <= 2'd0;
            end else if (slot_end) begin
                cnt <= 16'd0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end

            frame_tick <= frame_end;

            if (xfer) begin
                disp_q <= pend_q;
            end
            if (load) begin
                pend_q <= value;
            end
            busy <= load | (busy & ~xfer);

            // All anodes off on the first cycle of each slot so the previous digit cannot ghost
            if (!en || cnt == 16'd0) begin
                anode_n <= 4'b1111;
            end else begin
                anode_n <= ~(4'b0001 << idx);
            end
            digit_code <= code_next;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - scoreboard bench for display_scanner with REFRESH_DIV=4
module tb_display_scanner;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [4:0]  digit_code;
    logic [3:0]  anode_n;
    logic        busy;
    logic        frame_tick;

    display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [4:0] code;
        logic       busy;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int          m_cnt;
    int          m_idx;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_busy;
    logic [4:0]  seen[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Reference behaviour for one clock, evaluated from the inputs presented before the edge
    task automatic step();
        exp_t e;
        logic slot_end, fb, xfer;
        logic [15:0] upper;
        int zeros;
        if (rst) begin
            e.an = 4'b1111; e.code = 5'd16; e.busy = 1'b0; e.tick = 1'b0;
            m_cnt = 0; m_idx = 0; m_disp = 16'h0; m_pend = 16'h0; m_busy = 1'b0;
        end else begin
            slot_end = en && (m_cnt == DIV - 1);
            fb       = slot_end && (m_idx == 3);
            e.an     = (!en || m_cnt == 0) ? 4'b1111 : ~(4'b0001 << m_idx);
            upper    = m_disp >> (4 * m_idx);
            if (!en) e.code = 5'd16;
            else if (blank_lz && m_idx > 0 && upper == 16'h0) e.code = 5'd16;
            else e.code = {1'b0, upper[3:0]};
            xfer = m_busy && (fb || !en);
            e.tick = fb;
            if (xfer) m_disp = m_pend;
            if (load) m_pend = value;
            m_busy = load || (m_busy && !xfer);
            e.busy = m_busy;
            if (!en) begin
                m_cnt = 0; m_idx = 0;
            end else if (slot_end) begin
                m_cnt = 0; m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("anode_n", 32'(anode_n), 32'(e.an));
        check("digit_code", 32'(digit_code), 32'(e.code));
        check("busy", 32'(busy), 32'(e.busy));
        check("frame_tick", 32'(frame_tick), 32'(e.tick));
        zeros = 0;
        for (int i = 0; i < 4; i++) if (anode_n[i] == 1'b0) zeros++;
        check("anode_onehot", 32'(zeros <= 1), 32'd1);
        for (int i = 0; i < 4; i++) if (anode_n[i] == 1'b0) seen[i] = digit_code;
    endtask

    task automatic capture_frame();
        for (int i = 0; i < 4; i++) seen[i] = 5'h1F;
        for (int i = 0; i < 4 * DIV; i++) step();
    endtask

    task automatic sync_frame();
        int guard;
        guard = 0;
        load = 1'b0;
        step();
        while (frame_tick !== 1'b1 && guard < 64) begin
            step();
            guard++;
        end
        if (frame_tick !== 1'b1) check("frame_tick_timeout", 32'd0, 32'd1);
        capture_frame();
    endtask

    task automatic check_digits(input string tag, input logic [4:0] d0, input logic [4:0] d1,
                                input logic [4:0] d2, input logic [4:0] d3);
        check({tag, "_d0"}, 32'(seen[0]), 32'(d0));
        check({tag, "_d1"}, 32'(seen[1]), 32'(d1));
        check({tag, "_d2"}, 32'(seen[2]), 32'(d2));
        check({tag, "_d3"}, 32'(seen[3]), 32'(d3));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; value = 16'hFFFF; blank_lz = 1'b1;
        step();
        load = 1'b0;
        step();
        check("rst_anode", 32'(anode_n), 32'hF);
        check("rst_code", 32'(digit_code), 32'd16);
        check("rst_busy", 32'(busy), 32'd0);

        // Idle scan after reset with leading-zero blanking
        rst = 1'b0;
        step();
        check("first_guard", 32'(anode_n), 32'hF);
        step();
        check("first_digit0_an", 32'(anode_n), 32'hE);
        check("first_digit0_code", 32'(digit_code), 32'd0);
        sync_frame();
        check_digits("idle_blank", 5'd0, 5'd16, 5'd16, 5'd16);

        // Mid-frame load shows up on the following frame
        blank_lz = 1'b0;
        for (int i = 0; i < 5; i++) step();
        value = 16'h1A3F; load = 1'b1;
        step();
        load = 1'b0;
        check("busy_after_load", 32'(busy), 32'd1);
        sync_frame();
        check_digits("val_1a3f", 5'd15, 5'd3, 5'd10, 5'd1);
        check("busy_after_xfer", 32'(busy), 32'd0);

        value = 16'h00C0; load = 1'b1; blank_lz = 1'b1;
        step();
        sync_frame();
        check_digits("c0_blank", 5'd0, 5'd12, 5'd16, 5'd16);
        blank_lz = 1'b0;
        sync_frame();
        check_digits("c0_noblank", 5'd0, 5'd12, 5'd0, 5'd0);

        // Last load wins
        value = 16'h1111; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        value = 16'h2222; load = 1'b1;
        step();
        sync_frame();
        check_digits("last_wins", 5'd2, 5'd2, 5'd2, 5'd2);

        // Load on the boundary cycle: old pending shown now, new one next frame
        value = 16'h3333; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 64 && !(m_cnt == DIV - 1 && m_idx == 3); i++) step();
        value = 16'h4444; load = 1'b1;
        step();
        load = 1'b0;
        check("boundary_tick", 32'(frame_tick), 32'd1);
        check("boundary_busy", 32'(busy), 32'd1);
        capture_frame();
        check_digits("boundary_old", 5'd3, 5'd3, 5'd3, 5'd3);
        sync_frame();
        check_digits("boundary_new", 5'd4, 5'd4, 5'd4, 5'd4);

        // Going dark forces the transfer
        value = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        en = 1'b0;
        step();
        check("dark_busy", 32'(busy), 32'd0);
        check("dark_anode", 32'(anode_n), 32'hF);
        check("dark_code", 32'(digit_code), 32'd16);
        step();
        en = 1'b1;
        step();
        check("restart_guard", 32'(anode_n), 32'hF);
        step();
        check("restart_an", 32'(anode_n), 32'hE);
        check("restart_code", 32'(digit_code), 32'd5);

        // Reset mid-slot discards pending value
        value = 16'h6666; load = 1'b1;
        step();
        load = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midrst_anode", 32'(anode_n), 32'hF);
        check("midrst_code", 32'(digit_code), 32'd16);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        sync_frame();
        check_digits("after_rst", 5'd0, 5'd0, 5'd0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  scan enable; 0 = display dark, scan held.
REQ-005 load  input  1  one-cycle strobe; capture value into pending register.
REQ-006 value  input  16  four hex digits; digit 0 = value[3:0] (rightmost), digit 3 = value[15:12].
REQ-007 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-008 digit_code  output  5  code to the 7-segment decoder: 0..15 = hex nibble, 16 = blank.
REQ-009 anode_n  output  4  digit select, active-low, one-hot-low; bit i = digit i.
REQ-010 busy  output  1  1 = pending value not yet shown.
REQ-011 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler cnt SHALL count 0..REFRESH_DIV-1 while en=1; slot end = en=1 and cnt=REFRESH_DIV-1; at slot end cnt<=0, idx<=idx+1 mod 4.
REQ-013 While en=0: cnt and idx SHALL be held at 0.
REQ-014 Frame boundary = slot end with idx=3; frame_tick SHALL be 1 in the cycle after it, 0 otherwise.
REQ-015 load=1: pend_q<=value, busy<=1 next cycle; later loads before transfer SHALL overwrite pend_q (last wins).
REQ-016 Transfer disp_q<=pend_q, busy<=0 SHALL occur on a frame boundary with busy=1, or on any cycle with en=0 and busy=1.
REQ-017 load coincident with transfer: transfer uses old pend_q; pend_q<=value; busy SHALL stay 1.
REQ-018 Displayed nibble for slot idx = disp_q[4*idx+3:4*idx]; disp_q SHALL change only per REQ-016 (no mid-frame tearing).
REQ-019 Blanking: blank_lz=1 and idx>0 and all nibbles of disp_q at positions >= idx are zero -> code 16; digit 0 never blanked; blank_lz=0 -> no blanking.
REQ-020 digit_code and anode_n SHALL be registered: values at cycle t+1 computed from cnt, idx, disp_q, en at cycle t (latency 1 clk).
REQ-021 anode_n SHALL be 4'b1111 when en=0 or cnt=0 (one-cycle ghosting guard per slot), else ~(4'b0001<<idx).
REQ-022 digit_code SHALL be 16 when en=0, else code per REQ-018/019 (valid also during guard cycle).
REQ-023 en falling mid-slot: next cycle anode_n=4'b1111, digit_code=16; en rising restarts at idx=0, cnt=0.
REQ-024 No output SHALL ever drive more than one anode_n bit low.

Reset
REQ-025 rst=1 SHALL set on next edge: cnt=0, idx=0, disp_q=0, pend_q=0, busy=0, frame_tick=0, anode_n=4'b1111, digit_code=16.
REQ-026 rst SHALL override load and en in the same cycle; rst mid-frame discards pending value.
REQ-027 First post-reset output with en=1 SHALL be digit 0 of disp_q=0 (code 0) after the guard cycle.

Verification (REFRESH_DIV=4)
REQ-028 rst, en=1, no load -> anode_n sequence per slot 1111,1110,1110,1110 then 1111,1101,...; digit_code 0 on digit 0, 16 on digits 1-3 when blank_lz=1.
REQ-029 load value=16'h1A3F mid-frame, blank_lz=0 -> busy=1 until frame_tick; following frame codes 15,3,10,1 on digits 0..3.
REQ-030 value=16'h00C0, blank_lz=1 -> codes 0,12,16,16; blank_lz=0 -> 0,12,0,0.
REQ-031 Two loads (16'h1111 then 16'h2222) within one frame -> only 2s displayed; load on frame-boundary cycle -> old pending shown, busy stays 1, new value shown next frame.
REQ-032 en=0 while busy=1 -> transfer next cycle, busy=0, anode_n=1111, digit_code=16; en=1 -> scan restarts digit 0.
REQ-033 rst asserted mid-slot with busy=1 -> next cycle all outputs per REQ-025; check REQ-024 across full run.
